uart_tx_fifo_ctrl: RTL
======================

Name: uart_tx_fifo_ctrl

Overview:
Controller around the UART TX FIFO on the DE10-Lite UART design. Shares the FIFO write port between two byte sources using a round-robin arbiter. Drains the FIFO into the UART transmitter one frame at a time, with a programmable idle gap between frames. Sits between the byte producers (the write-pulse generator and the RX echo path) and the TX serializer.

Parameters:
- DATA_W, 8: byte width on all data ports.
- GAP_CYCLES, 16: idle ckht cycles inserted after each tx_done. A value of 0 means no gap.
- TIMEOUT_CYCLES, 65535: watchdog limit while waiting for tx_done. Used only with UART_TX_TIMEOUT_EN.

Ports:
- ckht  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  source 0 has a byte
- req0_data  in  DATA_W  source 0 byte
- req0_ready  out  1  source 0 byte accepted this cycle
- req1_valid  in  1  source 1 has a byte
- req1_data  in  DATA_W  source 1 byte
- req1_ready  out  1  source 1 byte accepted this cycle
- fifo_wr_en  out  1  FIFO write strobe
- fifo_wr_data  out  DATA_W  FIFO write data
- fifo_full  in  1  FIFO full
- fifo_rd_en  out  1  FIFO read strobe; FIFO read data is valid the cycle after
- fifo_rd_data  in  DATA_W  FIFO read data
- fifo_empty  in  1  FIFO empty
- tx_start  out  1  one-cycle start pulse to the serializer
- tx_data  out  DATA_W  byte for the serializer; held stable from START until the next LOAD
- tx_busy  in  1  serializer busy
- tx_done  in  1  one-cycle pulse at the end of the stop bit
- ctrl_busy  out  1  high in any read-FSM state other than IDLE
- err_timeout  out  1  one-cycle watchdog pulse; tied 0 without the macro

Behaviour:
- Clocking and reset: one clock, ckht. rst is synchronous and active-high.
- Reset values: all outputs 0, tx_data = 0, read FSM = IDLE, round-robin pointer last = 1 (so source 0 wins the first conflict), gap and watchdog counters = 0.
- Reset asserted mid-frame aborts the sequence. FSM returns to IDLE on the next edge; no tx_start is issued for a byte already read.

Write arbiter (combinational grant, registered pointer):
- gnt0 = req0_valid & (!req1_valid | last==1); gnt1 = req1_valid & !gnt0.
- reqN_ready = gntN & !fifo_full. fifo_wr_en = req0_ready | req1_ready.
- fifo_wr_data = the granted source's data; 0 when nothing is granted.
- On each accepted write, last <= index of the accepted source. last is unchanged while fifo_full is high.
- fifo_full high: both ready signals low, no write, pointer frozen.
- Both sources continuously valid and the FIFO not full: writes alternate 0,1,0,1 at one byte per cycle.

Read sequencer FSM (Moore outputs):
- IDLE: if !fifo_empty & !tx_busy, go to RD.
- RD: fifo_rd_en = 1 for exactly one cycle; go to LOAD.
- LOAD: tx_data <= fifo_rd_data; go to START.
- START: tx_start = 1 for one cycle; go to WAIT.
- WAIT: on tx_done, go to GAP, or to IDLE if GAP_CYCLES == 0.
- GAP: counter counts 0..GAP_CYCLES-1, then go to IDLE. Counter is cleared on GAP entry.
- Latency: condition seen in IDLE at edge k gives fifo_rd_en in cycle k+1 and tx_start in cycle k+3.
- tx_done outside WAIT is ignored. tx_done in the same cycle as tx_start is ignored.
- Back-to-back frames: minimum spacing from tx_done to the next tx_start is GAP_CYCLES+4 cycles.
- Write side and read side run concurrently and do not interact except through fifo_full and fifo_empty.
- Unreachable FSM encodings go to IDLE.

Optional Feature:
UART_TX_TIMEOUT_EN.
- Defined: a watchdog counts cycles in WAIT. If TIMEOUT_CYCLES is reached with no tx_done, err_timeout pulses for 1 cycle and the FSM goes to IDLE without a gap; the byte is dropped. The counter clears on WAIT entry.
- Undefined: there is no counter, WAIT has no exit other than tx_done, and err_timeout is constant 0.

Test Plan:
- Reset, then a single write: req0_valid with 0x41, fifo_full=0 -> req0_ready and fifo_wr_en high the same cycle, fifo_wr_data=0x41, last=0.
- Both sources valid for 4 cycles (0xA0 / 0xB0), FIFO not full -> write order 0xA0, 0xB0, 0xA0, 0xB0. With fifo_full=1 in cycle 3: no write that cycle and the alternation resumes unchanged.
- Drain path: FIFO model holds 0x55, tx_busy=0, GAP_CYCLES=16 -> rd_en at k+1, tx_data=0x55 and tx_start at k+3. tx_done at k+20 leads to IDLE 16 cycles later; a second byte gives tx_start at k+40.
- GAP_CYCLES=0 with two bytes queued -> second tx_start exactly 4 cycles after the first tx_done. A stray tx_done in IDLE causes no transition.
- rst pulse during WAIT and again during GAP -> next cycle all outputs 0 and FSM in IDLE; the queued byte restarts from RD.
- With UART_TX_TIMEOUT_EN and TIMEOUT_CYCLES=100, tx_done withheld -> err_timeout pulses 100 cycles after WAIT entry, then the FSM is in IDLE. Without the macro: still in WAIT after 1000 cycles and err_timeout stays 0.

Source files
------------

// File: rtl/uart_tx_fifo_ctrl.sv
// UART TX FIFO controller: round-robin write arbiter plus frame read sequencer.
// Optional watchdog on the WAIT state: define UART_TX_TIMEOUT_EN.
module uart_tx_fifo_ctrl #(
    parameter int DATA_W         = 8,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              ckht,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    input  logic              fifo_full,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_empty,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_busy,
    input  logic              tx_done,
    output logic              ctrl_busy,
    output logic              err_timeout
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD    = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] START = 3'd3;
    localparam logic [2:0] WAIT  = 3'd4;
    localparam logic [2:0] GAP   = 3'd5;

    localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    logic          last;
    logic          gnt0;
    logic          gnt1;
    logic [2:0]    state;
    logic [GW-1:0] gap_cnt;
    logic          wd_hit;

    always_comb begin
        gnt0 = req0_valid & (!req1_valid | last);
        gnt1 = req1_valid & !gnt0;
    end

    assign req0_ready = gnt0 & !fifo_full;
    assign req1_ready = gnt1 & !fifo_full;
    assign fifo_wr_en = req0_ready | req1_ready;

    always_comb begin
        fifo_wr_data = '0;
        if (gnt0)
            fifo_wr_data = req0_data;
        else if (gnt1)
            fifo_wr_data = req1_data;
    end

    // last = 1 after reset so source 0 wins the first conflict
    always_ff @(posedge ckht) begin
        if (rst)
            last <= 1'b1;
        else if (req0_ready)
            last <= 1'b0;
        else if (req1_ready)
            last <= 1'b1;
    end

    always_ff @(posedge ckht) begin
        if (rst) begin
            state   <= IDLE;
            gap_cnt <= '0;
            tx_data <= '0;
        end else begin
            case (state)
                IDLE: if (!fifo_empty && !tx_busy) state <= RD;
                RD:   state <= LOAD;
                LOAD: begin
                    tx_data <= fifo_rd_data;
                    state   <= START;
                end
                START: state <= WAIT;
                WAIT: begin
                    gap_cnt <= '0;
                    if (tx_done)
                        state <= (GAP_CYCLES == 0) ? IDLE : GAP;
                    else if (wd_hit)
                        state <= IDLE;
                end
                GAP: begin
                    if (gap_cnt == GW'(GAP_LAST))
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fifo_rd_en = (state == RD);
    assign tx_start   = (state == START);
    assign ctrl_busy  = (state != IDLE);

`ifdef UART_TX_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] wd_cnt;

    // wd_cnt sits at 0 outside WAIT, so it is clear on every WAIT entry
    assign wd_hit = (state == WAIT) && !tx_done &&
                    (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ckht) begin
        if (rst) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= wd_hit;
            if (state == WAIT)
                wd_cnt <= wd_cnt + 1'b1;
            else
                wd_cnt <= '0;
        end
    end
`else
    assign wd_hit      = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule
